// File: rtl/disk_sd_scheduler.sv
// Arbitrates SD-card block transfers between a floppy track loader and HDD
// sector requests. A floppy track is loaded as SECS_PER_TRACK consecutive
// blocks into a track buffer; HDD requests move one block each.
module disk_sd_scheduler #(
  parameter int SECS_PER_TRACK = 13,
  parameter int TRACK_W        = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] fdd_track,
  input  logic               fdd_mounted,
  input  logic               fdd_remount,
  input  logic [15:0]        hdd_sector,
  input  logic               hdd_read,
  input  logic               hdd_write,
  input  logic               sd_ack,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic               sd_dev,
  output logic [3:0]         fdd_sec,
  output logic               fdd_loaded,
  output logic               cpu_wait
);

  typedef enum logic [2:0] {IDLE, FDD_REQ, FDD_XFER, HDD_REQ, HDD_XFER} state_e;
  typedef enum logic {GNT_FDD = 1'b0, GNT_HDD = 1'b1} grant_e;

  localparam logic [3:0] LAST_SEC = 4'(SECS_PER_TRACK - 1);

  state_e               state_q, state_d;
  grant_e               last_grant_q, last_grant_d;
  logic [31:0]          sd_lba_q, sd_lba_d;
  logic                 sd_rd_q, sd_rd_d;
  logic                 sd_wr_q, sd_wr_d;
  logic                 sd_dev_q, sd_dev_d;
  logic [3:0]           fdd_sec_q, fdd_sec_d;
  logic                 fdd_loaded_q, fdd_loaded_d;
  logic                 cpu_wait_q, cpu_wait_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 wr_pend_q, wr_pend_d;
  logic                 reload_q, reload_d;
  logic [TRACK_W-1:0]   cur_track_q, cur_track_d;
  logic                 ack_q;

  logic ack_rise, ack_fall, fdd_pend, hdd_pend;
  logic grant_fdd, grant_hdd, clr_rd, clr_wr;

  // Next-state, arbitration and output register inputs
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sd_lba_d     = sd_lba_q;
    sd_rd_d      = sd_rd_q;
    sd_wr_d      = sd_wr_q;
    sd_dev_d     = sd_dev_q;
    fdd_sec_d    = fdd_sec_q;
    fdd_loaded_d = fdd_loaded_q;
    cur_track_d  = cur_track_q;
    clr_rd       = 1'b0;
    clr_wr       = 1'b0;

    ack_rise  = sd_ack & ~ack_q;
    ack_fall  = ~sd_ack & ack_q;
    fdd_pend  = fdd_mounted & ((cur_track_q != fdd_track) | reload_q);
    hdd_pend  = rd_pend_q | wr_pend_q;
    grant_fdd = (state_q == IDLE) & fdd_pend & (~hdd_pend | (last_grant_q == GNT_HDD));
    grant_hdd = (state_q == IDLE) & hdd_pend & (~fdd_pend | (last_grant_q == GNT_FDD));

    case (state_q)
      IDLE: begin
        if (grant_fdd) begin
          cur_track_d  = fdd_track;
          fdd_sec_d    = '0;
          sd_lba_d     = 32'(fdd_track) * 32'(SECS_PER_TRACK);
          sd_dev_d     = 1'b0;
          sd_rd_d      = 1'b1;
          sd_wr_d      = 1'b0;
          last_grant_d = GNT_FDD;
          state_d      = FDD_REQ;
        end else if (grant_hdd) begin
          sd_lba_d     = {16'b0, hdd_sector};
          sd_dev_d     = 1'b1;
          sd_rd_d      = rd_pend_q;
          sd_wr_d      = ~rd_pend_q;
          last_grant_d = GNT_HDD;
          state_d      = HDD_REQ;
        end
      end
      FDD_REQ: begin
        if (ack_rise) begin
          sd_rd_d = 1'b0;
          state_d = FDD_XFER;
        end
      end
      FDD_XFER: begin
        if (ack_fall) begin
          if ((fdd_sec_q == LAST_SEC) || !fdd_mounted) begin
            state_d = IDLE;
            if ((fdd_sec_q == LAST_SEC) && fdd_mounted) fdd_loaded_d = 1'b1;
          end else begin
            fdd_sec_d = fdd_sec_q + 4'd1;
            sd_lba_d  = sd_lba_q + 32'd1;
            sd_rd_d   = 1'b1;
            state_d   = FDD_REQ;
          end
        end
      end
      HDD_REQ: begin
        if (ack_rise) begin
          // the strobe still high identifies which pending bit was serviced
          clr_rd  = sd_rd_q;
          clr_wr  = sd_wr_q;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = HDD_XFER;
        end
      end
      HDD_XFER: begin
        if (ack_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a new request pulse wins over a same-cycle clear
    rd_pend_d = (rd_pend_q & ~clr_rd) | hdd_read;
    wr_pend_d = (wr_pend_q & ~clr_wr) | hdd_write;
    reload_d  = (reload_q & ~grant_fdd) | fdd_remount;

    // a completed load whose track has since moved must not claim validity
    if ((fdd_track != cur_track_q) || fdd_remount || grant_fdd) fdd_loaded_d = 1'b0;

    cpu_wait_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_HDD;
      sd_lba_q     <= '0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      sd_dev_q     <= 1'b0;
      fdd_sec_q    <= '0;
      fdd_loaded_q <= 1'b0;
      cpu_wait_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      reload_q     <= 1'b1;
      cur_track_q  <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sd_lba_q     <= sd_lba_d;
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
      sd_dev_q     <= sd_dev_d;
      fdd_sec_q    <= fdd_sec_d;
      fdd_loaded_q <= fdd_loaded_d;
      cpu_wait_q   <= cpu_wait_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      reload_q     <= reload_d;
      cur_track_q  <= cur_track_d;
      ack_q        <= sd_ack;
    end
  end

  assign sd_lba     = sd_lba_q;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign sd_dev     = sd_dev_q;
  assign fdd_sec    = fdd_sec_q;
  assign fdd_loaded = fdd_loaded_q;
  assign cpu_wait   = cpu_wait_q;

endmodule

// File: tb/tb_disk_sd_scheduler.sv
// Bench for disk_sd_scheduler: an SD host model answers each strobe and a
// scoreboard compares every observed block request against expectations.
module tb_disk_sd_scheduler;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  fdd_track = '0;
  logic        fdd_mounted = 1'b0;
  logic        fdd_remount = 1'b0;
  logic [15:0] hdd_sector = '0;
  logic        hdd_read = 1'b0;
  logic        hdd_write = 1'b0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_dev, fdd_loaded, cpu_wait;
  logic [3:0]  fdd_sec;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        dev;
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } xact_t;

  xact_t exp_q[$];

  disk_sd_scheduler #(.SECS_PER_TRACK(13), .TRACK_W(6)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .fdd_track(fdd_track),
    .fdd_mounted(fdd_mounted), .fdd_remount(fdd_remount),
    .hdd_sector(hdd_sector), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_dev(sd_dev), .fdd_sec(fdd_sec), .fdd_loaded(fdd_loaded),
    .cpu_wait(cpu_wait)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_fdd(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b1, 1'b0, base + 32'(i), 4'(i)});
  endtask

  task automatic push_hdd(input logic rd, input logic [15:0] sec);
    exp_q.push_back({1'b1, rd, ~rd, {16'b0, sec}, 4'h0});
  endtask

  // SD host model and scoreboard monitor: one transaction per strobe
  initial begin : host
    xact_t act, exp;
    forever begin
      @(negedge clk_sys);
      if (reset_n && (sd_rd || sd_wr)) begin
        act = {sd_dev, sd_rd, sd_wr, sd_lba, sd_dev ? 4'h0 : fdd_sec};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xact: got 0x%0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("xact", 64'(act), 64'(exp));
        end
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  task automatic pulse(input logic rd, input logic wr);
    @(posedge clk_sys); #1;
    hdd_read = rd; hdd_write = wr;
    @(posedge clk_sys); #1;
    hdd_read = 1'b0; hdd_write = 1'b0;
  endtask

  // Waits for the scheduler to drain all expected work and go idle
  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !cpu_wait && !sd_ack) && n < 3000) begin
      @(posedge clk_sys); #1; n++;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    if (n >= 3000) check({name, "_timeout"}, 64'(n), 64'(0));
  endtask

  // which: 0 = fdd_sec equals val, 1 = sd_wr high, 2 = sd_ack high
  task automatic wait_cond(input string name, input int which, input logic [3:0] val);
    int  n = 0;
    logic hit = 1'b0;
    while (!hit && n < 3000) begin
      @(posedge clk_sys); #1; n++;
      case (which)
        0:       hit = (fdd_sec == val);
        1:       hit = sd_wr;
        default: hit = sd_ack;
      endcase
    end
    if (!hit) check({name, "_timeout"}, 64'(n), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_outputs", {sd_lba, sd_rd, sd_wr, sd_dev, fdd_sec, fdd_loaded, cpu_wait}, '0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // track 0 loads after reset because reload starts set
    push_fdd(32'd0, 13);
    fdd_mounted = 1'b1;
    wait_done("t0");
    check("t0_loaded", 64'(fdd_loaded), 64'(1));
    check("t0_wait", 64'(cpu_wait), 64'(0));

    // seek to track 5: lba 65..77
    push_fdd(32'd65, 13);
    fdd_track = 6'd5;
    @(posedge clk_sys); #1;
    check("t5_unloaded", 64'(fdd_loaded), 64'(0));
    wait_done("t5");
    check("t5_loaded", 64'(fdd_loaded), 64'(1));

    // HDD read 0x1234, strobe two edges after the pulse
    hdd_sector = 16'h1234;
    push_hdd(1'b1, 16'h1234);
    pulse(1'b1, 1'b0);
    @(posedge clk_sys); #1;
    check("hdd_latency", {sd_rd, sd_wr, sd_dev}, 3'b101);
    wait_done("hdd_rd");
    check("hdd_wait", 64'(cpu_wait), 64'(0));

    // track 3 load, HDD write mid-load, seek to 4 at block 6
    push_fdd(32'd39, 13);
    push_hdd(1'b0, 16'h0042);
    push_fdd(32'd52, 13);
    hdd_sector = 16'h0042;
    fdd_track  = 6'd3;
    wait_cond("t3_sec2", 0, 4'd2);
    pulse(1'b0, 1'b1);
    wait_cond("t3_sec6", 0, 4'd6);
    fdd_track = 6'd4;
    wait_cond("t3_wr", 1, 4'd0);
    check("t3_not_loaded", 64'(fdd_loaded), 64'(0));
    wait_done("t4");
    check("t4_loaded", 64'(fdd_loaded), 64'(1));

    // simultaneous read and write: read first
    hdd_sector = 16'h0100;
    push_hdd(1'b1, 16'h0100);
    push_hdd(1'b0, 16'h0100);
    pulse(1'b1, 1'b1);
    wait_done("rdwr");
    check("rdwr_wait", 64'(cpu_wait), 64'(0));

    // unmount during block 3 of track 7 (lba 91..94)
    push_fdd(32'd91, 4);
    fdd_track = 6'd7;
    wait_cond("t7_sec3", 0, 4'd3);
    fdd_mounted = 1'b0;
    wait_done("t7");
    check("t7_loaded", 64'(fdd_loaded), 64'(0));
    check("t7_wait", 64'(cpu_wait), 64'(0));

    // reset in the middle of an HDD transfer
    hdd_sector = 16'h0ABC;
    push_hdd(1'b1, 16'h0ABC);
    pulse(1'b1, 1'b0);
    wait_cond("rst_ack", 2, 4'd0);
    check("pre_rst_wait", 64'(cpu_wait), 64'(1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {sd_lba, sd_rd, sd_wr, sd_dev, fdd_sec, fdd_loaded, cpu_wait}, '0);
    repeat (8) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk_sys);
    #1;
    check("post_rst_idle", {sd_rd, sd_wr, cpu_wait}, 3'b000);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
